// File: rtl/damage_pkg.sv
// Shared definitions for the damage engine: FSM encoding, crit LFSR constants, HP helper.
// Latency: n/a (package). Backpressure: n/a.
package damage_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/damage_lane_alu.sv
// Combinational exchange of damage between the two units of one lane.
// Latency: 0 cycles. Backpressure: none (pure function of its inputs).
module damage_lane_alu
  import damage_pkg::*;
#(
  parameter int HP_W  = 8,
  parameter int ATK_W = 6
) (
  input  logic [HP_W-1:0]  pHp,
  input  logic [HP_W-1:0]  eHp,
  input  logic [ATK_W-1:0] pAtk,
  input  logic [ATK_W-1:0] pDef,
  input  logic [ATK_W-1:0] eAtk,
  input  logic [ATK_W-1:0] eDef,
  input  logic             pCrit,
  input  logic             eCrit,
  output logic [HP_W-1:0]  pHpNew,
  output logic [HP_W-1:0]  eHpNew,
  output logic             pDead,
  output logic             eDead
);

  logic [ATK_W-1:0] pRaw;
  logic [ATK_W-1:0] eRaw;
  logic [HP_W-1:0]  pDmg;
  logic [HP_W-1:0]  eDmg;
  logic [HP_W:0]    pDbl;
  logic [HP_W:0]    eDbl;

  // An absent attacker (HP 0) or a zero attack deals nothing; otherwise at least 1.
  always_comb begin
    pRaw = '0;
    eRaw = '0;
    if (pHp != '0 && pAtk != '0) pRaw = (pAtk > eDef) ? (pAtk - eDef) : ATK_W'(1);
    if (eHp != '0 && eAtk != '0) eRaw = (eAtk > pDef) ? (eAtk - pDef) : ATK_W'(1);
  end

  always_comb begin
    pDmg = {{(HP_W-ATK_W){1'b0}}, pRaw};
    eDmg = {{(HP_W-ATK_W){1'b0}}, eRaw};
    pDbl = {pDmg, 1'b0};
    eDbl = {eDmg, 1'b0};
    if (pCrit) pDmg = pDbl[HP_W] ? '1 : pDbl[HP_W-1:0];
    if (eCrit) eDmg = eDbl[HP_W] ? '1 : eDbl[HP_W-1:0];
  end

  // Both strikes use pre-damage HP, so a mutual kill falls out naturally.
  assign eHpNew = HP_W'(sat_sub(32'(eHp), 32'(pDmg)));
  assign pHpNew = HP_W'(sat_sub(32'(pHp), 32'(eDmg)));
  assign eDead  = (eHp != '0) && (eHpNew == '0);
  assign pDead  = (pHp != '0) && (pHpNew == '0);

endmodule

// File: rtl/damage_calc.sv
// Lane-by-lane damage pass: RD/WR per lane, then DONE held until damage_ack. Optional crits via DAMAGE_CALC_CRIT_EN.
// Latency: 2 cycles per lane, damage_done from cycle 2*LANES+1 after the start pulse.
// Backpressure: start ignored unless idle; damage_done held until damage_ack, ack wins over a same-cycle start.
module damage_calc
  import damage_pkg::*;
#(
  parameter int LANES = 8,
  parameter int HP_W  = 8,
  parameter int ATK_W = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         damage_scen,
  input  logic                         damage_ack,
  output logic [$clog2(LANES)-1:0]     lane_idx,
  input  logic [HP_W-1:0]              p_hp,
  input  logic [HP_W-1:0]              e_hp,
  input  logic [ATK_W-1:0]             p_atk,
  input  logic [ATK_W-1:0]             p_def,
  input  logic [ATK_W-1:0]             e_atk,
  input  logic [ATK_W-1:0]             e_def,
  output logic                         wr_en,
  output logic [$clog2(LANES)-1:0]     wr_idx,
  output logic [HP_W-1:0]              p_hp_new,
  output logic [HP_W-1:0]              e_hp_new,
  output logic                         p_dead,
  output logic                         e_dead,
  output logic [$clog2(LANES+1)-1:0]   p_kills,
  output logic [$clog2(LANES+1)-1:0]   e_kills,
  output logic                         busy,
  output logic                         damage_done
);

  localparam int IDX_W = $clog2(LANES);
  localparam int KIL_W = $clog2(LANES+1);

  logic [1:0]       state;
  logic [IDX_W-1:0] counter;
  logic             lastLane;
  logic             pCrit;
  logic             eCrit;
  logic [HP_W-1:0]  pHpNewC;
  logic [HP_W-1:0]  eHpNewC;
  logic             pDeadC;
  logic             eDeadC;

  assign busy        = (state == ST_RD) || (state == ST_WR);
  assign damage_done = (state == ST_DONE);
  assign lane_idx    = busy ? counter : '0;
  assign lastLane    = (counter == IDX_W'(LANES-1));

`ifdef DAMAGE_CALC_CRIT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (state == ST_WR) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign pCrit = lfsr[0];
  assign eCrit = lfsr[1];
`else
  assign pCrit = 1'b0;
  assign eCrit = 1'b0;
`endif

  // The ALU sees the lane file during RD; its result is captured as the WR-cycle write.
  damage_lane_alu #(
    .HP_W  (HP_W),
    .ATK_W (ATK_W)
  ) u_alu (
    .pHp    (p_hp),
    .eHp    (e_hp),
    .pAtk   (p_atk),
    .pDef   (p_def),
    .eAtk   (e_atk),
    .eDef   (e_def),
    .pCrit  (pCrit),
    .eCrit  (eCrit),
    .pHpNew (pHpNewC),
    .eHpNew (eHpNewC),
    .pDead  (pDeadC),
    .eDead  (eDeadC)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      counter  <= '0;
      wr_en    <= 1'b0;
      wr_idx   <= '0;
      p_hp_new <= '0;
      e_hp_new <= '0;
      p_dead   <= 1'b0;
      e_dead   <= 1'b0;
      p_kills  <= '0;
      e_kills  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (damage_scen) begin
            state   <= ST_RD;
            counter <= '0;
            p_kills <= '0;
            e_kills <= '0;
          end
        end
        ST_RD: begin
          state    <= ST_WR;
          wr_en    <= 1'b1;
          wr_idx   <= counter;
          p_hp_new <= pHpNewC;
          e_hp_new <= eHpNewC;
          p_dead   <= pDeadC;
          e_dead   <= eDeadC;
          // p_kills tallies enemy deaths, e_kills tallies player deaths
          if (eDeadC) p_kills <= p_kills + KIL_W'(1);
          if (pDeadC) e_kills <= e_kills + KIL_W'(1);
        end
        ST_WR: begin
          wr_en  <= 1'b0;
          p_dead <= 1'b0;
          e_dead <= 1'b0;
          if (lastLane) begin
            state <= ST_DONE;
          end else begin
            state   <= ST_RD;
            counter <= counter + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (damage_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_damage_calc.sv
// Randomized scoreboard bench for damage_calc: integer reference model, decoupled write monitor.
`timescale 1ns/1ps
module tb_damage_calc;

  localparam int LANES = 8;
  localparam int HP_W  = 8;
  localparam int ATK_W = 6;
  localparam int IW    = $clog2(LANES);
  localparam int KW    = $clog2(LANES+1);
  localparam int HPMAX = (1 << HP_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic damage_scen = 1'b0;
  logic damage_ack = 1'b0;
  logic [IW-1:0] lane_idx, wr_idx;
  logic [HP_W-1:0] p_hp, e_hp, p_hp_new, e_hp_new;
  logic [ATK_W-1:0] p_atk, p_def, e_atk, e_def;
  logic wr_en, p_dead, e_dead, busy, damage_done;
  logic [KW-1:0] p_kills, e_kills;

  // Lane file seen by the DUT
  logic [HP_W-1:0]  fPHp [LANES];
  logic [HP_W-1:0]  fEHp [LANES];
  logic [ATK_W-1:0] fPAtk[LANES];
  logic [ATK_W-1:0] fPDef[LANES];
  logic [ATK_W-1:0] fEAtk[LANES];
  logic [ATK_W-1:0] fEDef[LANES];

  assign p_hp  = fPHp[lane_idx];
  assign e_hp  = fEHp[lane_idx];
  assign p_atk = fPAtk[lane_idx];
  assign p_def = fPDef[lane_idx];
  assign e_atk = fEAtk[lane_idx];
  assign e_def = fEDef[lane_idx];

  always #5 clk = ~clk;

  damage_calc #(.LANES(LANES), .HP_W(HP_W), .ATK_W(ATK_W)) dut (
    .clk(clk), .reset_n(reset_n), .damage_scen(damage_scen), .damage_ack(damage_ack),
    .lane_idx(lane_idx), .p_hp(p_hp), .e_hp(e_hp), .p_atk(p_atk), .p_def(p_def),
    .e_atk(e_atk), .e_def(e_def), .wr_en(wr_en), .wr_idx(wr_idx),
    .p_hp_new(p_hp_new), .e_hp_new(e_hp_new), .p_dead(p_dead), .e_dead(e_dead),
    .p_kills(p_kills), .e_kills(e_kills), .busy(busy), .damage_done(damage_done)
  );

  typedef struct {
    int idx;
    int pNew;
    int eNew;
    int pDead;
    int eDead;
  } wr_t;

  wr_t expQ[$];
  wr_t monE;
  int  tests = 0;
  int  fails = 0;
  int  expPKills, expEKills;
  int  pendP[LANES];
  int  pendE[LANES];
  int  tbLfsr = 16'hACE1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Damage rules as plain integer arithmetic
  function automatic int rawDmg(input int hp, input int atk, input int def, input int crit);
    int d;
    if (hp == 0 || atk == 0) return 0;
    d = (atk > def) ? atk - def : 1;
    if (crit != 0) d = (2 * d > HPMAX) ? HPMAX : 2 * d;
    return d;
  endfunction

  function automatic int hit(input int hp, input int d);
    return (hp > d) ? hp - d : 0;
  endfunction

  task automatic plan(input int n);
    int pc, ec, pd, ed, pn, en, pdd, edd, b;
    expPKills = 0;
    expEKills = 0;
    for (int k = 0; k < n; k++) begin
      pc = 0;
      ec = 0;
`ifdef DAMAGE_CALC_CRIT_EN
      pc = tbLfsr % 2;
      ec = (tbLfsr / 2) % 2;
      b = ((tbLfsr >> 15) ^ (tbLfsr >> 13) ^ (tbLfsr >> 12) ^ (tbLfsr >> 10)) & 1;
      tbLfsr = ((tbLfsr << 1) & 16'hFFFF) | b;
`else
      b = 0;
`endif
      pd  = rawDmg(int'(fPHp[k]), int'(fPAtk[k]), int'(fEDef[k]), pc);
      ed  = rawDmg(int'(fEHp[k]), int'(fEAtk[k]), int'(fPDef[k]), ec);
      en  = hit(int'(fEHp[k]), pd);
      pn  = hit(int'(fPHp[k]), ed);
      pdd = (fPHp[k] != 0 && pn == 0) ? 1 : 0;
      edd = (fEHp[k] != 0 && en == 0) ? 1 : 0;
      expPKills += edd;
      expEKills += pdd;
      pendP[k] = pn;
      pendE[k] = en;
      expQ.push_back('{idx: k, pNew: pn, eNew: en, pDead: pdd, eDead: edd});
    end
  endtask

  task automatic commit(input int n);
    for (int k = 0; k < n; k++) begin
      fPHp[k] = HP_W'(pendP[k]);
      fEHp[k] = HP_W'(pendE[k]);
    end
  endtask

  task automatic randLanes();
    for (int k = 0; k < LANES; k++) begin
      fPHp[k]  = ($urandom_range(0, 4) == 0) ? '0 : HP_W'($urandom_range(1, HPMAX));
      fEHp[k]  = ($urandom_range(0, 4) == 0) ? '0 : HP_W'($urandom_range(1, 40));
      fPAtk[k] = ($urandom_range(0, 5) == 0) ? '0 : ATK_W'($urandom_range(1, 63));
      fPDef[k] = ATK_W'($urandom_range(0, 63));
      fEAtk[k] = ATK_W'($urandom_range(0, 63));
      fEDef[k] = ($urandom_range(0, 3) == 0) ? fPAtk[k] : ATK_W'($urandom_range(0, 20));
    end
  endtask

  // Scoreboard monitor: every write must match the head of the expectation queue
  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      if (expQ.size() == 0) begin
        check("unexpected_wr_en", 1, 0);
      end else begin
        monE = expQ.pop_front();
        check("wr_idx",   int'(wr_idx),   monE.idx);
        check("p_hp_new", int'(p_hp_new), monE.pNew);
        check("e_hp_new", int'(e_hp_new), monE.eNew);
        check("p_dead",   int'(p_dead),   monE.pDead);
        check("e_dead",   int'(e_dead),   monE.eDead);
      end
    end
  end

  task automatic runPass();
    int cyc;
    plan(LANES);
    @(negedge clk);
    damage_scen = 1'b1;
    @(posedge clk);
    #1 damage_scen = 1'b0;
    @(negedge clk);
    cyc = 1;
    check("busy_first_rd", int'(busy), 1);
    while (!damage_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", cyc, 2 * LANES + 1);
    check("p_kills", int'(p_kills), expPKills);
    check("e_kills", int'(e_kills), expEKills);
    check("writes_all_seen", expQ.size(), 0);
    check("busy_in_done", int'(busy), 0);
    check("lane_idx_in_done", int'(lane_idx), 0);
    commit(LANES);
  endtask

  task automatic ackDone();
    @(negedge clk);
    damage_ack = 1'b1;
    @(posedge clk);
    #1 damage_ack = 1'b0;
    @(negedge clk);
    check("done_after_ack", int'(damage_done), 0);
  endtask

  task automatic checkResetOutputs();
    check("rst_wr_en",    int'(wr_en), 0);
    check("rst_wr_idx",   int'(wr_idx), 0);
    check("rst_lane_idx", int'(lane_idx), 0);
    check("rst_p_hp_new", int'(p_hp_new), 0);
    check("rst_e_hp_new", int'(e_hp_new), 0);
    check("rst_dead",     int'({p_dead, e_dead}), 0);
    check("rst_kills",    int'({p_kills, e_kills}), 0);
    check("rst_busy",     int'(busy), 0);
    check("rst_done",     int'(damage_done), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    randLanes();
    #2 checkResetOutputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Ack while idle is ignored
    damage_ack = 1'b1;
    @(negedge clk);
    damage_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_busy", int'(busy), 0);
    check("idle_ack_done", int'(damage_done), 0);

    // Directed lanes: plain exchange, a kill, an absent player
    fPHp[0] = 8'd20; fPAtk[0] = 6'd10; fPDef[0] = 6'd3;
    fEHp[0] = 8'd15; fEAtk[0] = 6'd5;  fEDef[0] = 6'd4;
    fPHp[3] = 8'd50; fPAtk[3] = 6'd30; fEDef[3] = 6'd2; fEHp[3] = 8'd10;
    fPHp[5] = 8'd0;  fEAtk[5] = 6'd40; fEHp[5] = 8'd25; fPAtk[5] = 6'd20;
    runPass();

    // DONE held while ack stays low, then ack beats a simultaneous start
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("done_held", int'(damage_done), 1);
    end
    @(negedge clk);
    damage_ack = 1'b1;
    damage_scen = 1'b1;
    @(posedge clk);
    #1 damage_ack = 1'b0;
    damage_scen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_restart_done", int'(damage_done), 0);
      check("no_restart_busy", int'(busy), 0);
    end

    // Boundary lanes: atk==def, zero attack, exact lethal, both absent, saturating hp
    randLanes();
    fPHp[1] = 8'd30; fPAtk[1] = 6'd10; fEDef[1] = 6'd4;  fEHp[1] = 8'd6;  fEAtk[1] = 6'd0;
    fPHp[2] = 8'd1;  fPAtk[2] = 6'd7;  fEDef[2] = 6'd7;  fEHp[2] = 8'd1;  fEAtk[2] = 6'd9;  fPDef[2] = 6'd9;
    fPHp[4] = 8'd0;  fEHp[4] = 8'd0;   fPAtk[4] = 6'd63; fEAtk[4] = 6'd63;
    fPHp[6] = 8'd255; fEAtk[6] = 6'd63; fPDef[6] = 6'd0; fEHp[6] = 8'd200; fPAtk[6] = 6'd0;
    runPass();
    ackDone();

    for (int r = 0; r < 3; r++) begin
      randLanes();
      runPass();
      ackDone();
    end

    // Reset in cycle 6 (WR of lane 2): only lanes 0 and 1 were written
    randLanes();
    plan(2);
    @(negedge clk);
    damage_scen = 1'b1;
    @(posedge clk);
    #1 damage_scen = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 checkResetOutputs();
    check("abort_writes_seen", expQ.size(), 0);
    expQ.delete();
    commit(2);
    tbLfsr = 16'hACE1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_no_wr", int'(wr_en), 0);
    end
    runPass();
    ackDone();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
